gbus_arbiter: RTL and testbench

GBUS_ARBITER -- requirements
Module: gbus_arbiter

---
 rtl/gbus_arbiter.sv | 141 ++++++++++++++
 tb/tb_gbus_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbus_arbiter.sv
// Round-robin bus arbiter: grants one master a burst of up to MAX_BURST beats, then a TURN/IDLE gap.
// Define GBUS_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module gbus_arbiter #(
  parameter int unsigned NUM_MSTR  = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                         sysClk,
  input  logic                         rst,
  input  logic [NUM_MSTR-1:0]          need,
  output logic [NUM_MSTR-1:0]          YouGotIt,
  input  logic [NUM_MSTR*ADDR_W-1:0]   addrM,
  input  logic [NUM_MSTR*DATA_W-1:0]   DoutM,
  output logic [DATA_W-1:0]            DinMast,
  output logic [NUM_MSTR-1:0]          Clast_mstr,
  output logic [ADDR_W-1:0]            Adr,
  output logic [DATA_W-1:0]            dbus_in,
  input  logic [DATA_W-1:0]            dataOut,
  output logic                         tarActive,
  output logic                         Clast
);

  localparam int unsigned OW = $clog2(NUM_MSTR);
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t          r_state, w_next;
  logic [OW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   w_win, w_lo;
  logic            w_found_lo;
  logic            w_sel_need;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dout;
`ifndef GBUS_FIXED_PRI_EN
  localparam logic [OW-1:0] LAST_MSTR = OW'(NUM_MSTR - 1);
  logic [OW-1:0]   r_ptr, w_hi;
  logic            w_found_hi;
`endif

  // Round-robin as two priority scans: first request at/above the pointer, else lowest overall.
  always_comb begin
    w_lo       = '0;
    w_found_lo = 1'b0;
`ifndef GBUS_FIXED_PRI_EN
    w_hi       = '0;
    w_found_hi = 1'b0;
`endif
    for (int unsigned j = 0; j < NUM_MSTR; j++) begin
      if (need[j] && !w_found_lo) begin
        w_lo       = OW'(j);
        w_found_lo = 1'b1;
      end
`ifndef GBUS_FIXED_PRI_EN
      if (need[j] && (OW'(j) >= r_ptr) && !w_found_hi) begin
        w_hi       = OW'(j);
        w_found_hi = 1'b1;
      end
`endif
    end
`ifdef GBUS_FIXED_PRI_EN
    w_win = w_lo;
`else
    w_win = w_found_hi ? w_hi : w_lo;
`endif
  end

  always_comb begin
    w_sel_need = 1'b0;
    w_adr      = '0;
    w_dout     = '0;
    for (int unsigned m = 0; m < NUM_MSTR; m++) begin
      if (OW'(m) == r_owner) begin
        w_sel_need = need[m];
        w_adr      = addrM[m*ADDR_W +: ADDR_W];
        w_dout     = DoutM[m*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sysClk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    YouGotIt   = '0;
    Clast_mstr = '0;
    tarActive  = 1'b0;
    Clast      = 1'b0;
    Adr        = '0;
    dbus_in    = '0;
    DinMast    = '0;
    unique case (r_state)
      IDLE: if (|need) w_next = BUSY;
      BUSY: begin
        tarActive = w_sel_need;
        Clast     = w_sel_need && (r_cnt == LAST_BEAT);
        Adr       = w_adr;
        dbus_in   = w_dout;
        DinMast   = dataOut;
        for (int unsigned m = 0; m < NUM_MSTR; m++) begin
          if (OW'(m) == r_owner) begin
            YouGotIt[m]   = 1'b1;
            Clast_mstr[m] = Clast;
          end
        end
        if (!w_sel_need || Clast) w_next = TURN;
      end
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge rst) begin
    if (!rst) begin
      r_owner <= '0;
      r_cnt   <= '0;
`ifndef GBUS_FIXED_PRI_EN
      r_ptr   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (|need) begin
          r_owner <= w_win;
          r_cnt   <= '0;
        end
        BUSY: if (w_sel_need) r_cnt <= r_cnt + 1'b1;
`ifndef GBUS_FIXED_PRI_EN
        TURN: r_ptr <= (r_owner == LAST_MSTR) ? '0 : r_owner + 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbus_arbiter.sv
// Self-checking bench for gbus_arbiter: directed scenarios plus randomized traffic
// compared against a grant/beat-level reference model.
module tb_gbus_arbiter;

  localparam int NM = 4;
  localparam int DW = 16;
  localparam int AW = 48;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     need = '0;
  logic [NM-1:0]     YouGotIt, Clast_mstr;
  logic [NM*AW-1:0]  addrM;
  logic [NM*DW-1:0]  DoutM;
  logic [DW-1:0]     DinMast, dbus_in, dataOut = '0;
  logic [AW-1:0]     Adr;
  logic              tarActive, Clast;

  logic [AW-1:0]     a_addr [NM];
  logic [DW-1:0]     a_dout [NM];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current grant holder (-1 = none), beats moved, dead cycles left, next-scan start.
  int m_owner = -1;
  int m_beats = 0;
  int m_gap   = 0;
  int m_ptr   = 0;

  logic [NM-1:0] e_grant, e_cmstr;
  logic          e_act, e_clast;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dbus, e_din;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      addrM[i*AW +: AW] = a_addr[i];
      DoutM[i*DW +: DW] = a_dout[i];
    end
  end

  gbus_arbiter #(
    .NUM_MSTR (NM),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_BURST(MB)
  ) dut (
    .sysClk    (clk),
    .rst       (rst_n),
    .need      (need),
    .YouGotIt  (YouGotIt),
    .addrM     (addrM),
    .DoutM     (DoutM),
    .DinMast   (DinMast),
    .Clast_mstr(Clast_mstr),
    .Adr       (Adr),
    .dbus_in   (dbus_in),
    .dataOut   (dataOut),
    .tarActive (tarActive),
    .Clast     (Clast)
  );

  function automatic int pick_winner(input logic [NM-1:0] req, input int ptr);
    int idx;
`ifdef GBUS_FIXED_PRI_EN
    for (int k = 0; k < NM; k++) begin
      idx = k;
      if (req[idx[1:0]]) return idx;
    end
`else
    for (int k = 0; k < NM; k++) begin
      idx = (ptr + k) % NM;
      if (req[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_gap = 0; m_ptr = 0;
  endtask

  task automatic exp_calc();
    int o;
    e_grant = '0; e_cmstr = '0; e_act = 1'b0; e_clast = 1'b0;
    e_adr = '0; e_dbus = '0; e_din = '0;
    if (m_owner >= 0) begin
      o       = m_owner;
      e_grant = 4'b0001 << o;
      e_act   = need[o[1:0]];
      e_clast = e_act && (m_beats == MB - 1);
      e_cmstr = e_clast ? e_grant : '0;
      e_adr   = a_addr[o[1:0]];
      e_dbus  = a_dout[o[1:0]];
      e_din   = dataOut;
    end
  endtask

  task automatic model_edge();
    int  o;
    logic act, last;
    if (m_owner >= 0) begin
      o    = m_owner;
      act  = need[o[1:0]];
      last = act && (m_beats == MB - 1);
      if (act) m_beats++;
      if (!act || last) begin
`ifdef GBUS_FIXED_PRI_EN
        m_ptr = 0;
`else
        m_ptr = (m_owner + 1) % NM;
`endif
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (need != '0) begin
      m_owner = pick_winner(need, m_ptr);
      m_beats = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    exp_calc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    need  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    need  = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if ({YouGotIt, Clast_mstr, tarActive, Clast, Adr, dbus_in, DinMast} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b act=%b adr=%h got nonzero, want all 0", YouGotIt, tarActive, Adr);
    end
    need = 4'b0010;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (YouGotIt !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle_grant: got %b want 0000", YouGotIt);
    end
    adv();
    settle();
    n_tests++;
    if (YouGotIt !== 4'b0010) begin
      n_fail++;
      $display("FAIL first_arb_after_reset: got %b want 0010", YouGotIt);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    need = 4'b0010;
    settle();
    n_tests++;
    if (YouGotIt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 0000", YouGotIt);
    end
    adv();
    for (int b = 1; b <= MB; b++) begin
      settle();
      n_tests++;
      if ({YouGotIt, tarActive, Clast, Clast_mstr} !== {4'b0010, 1'b1, (b == MB), (b == MB) ? 4'b0010 : 4'b0000}) begin
        n_fail++;
        $display("FAIL single_beat%0d: grant=%b act=%b clast=%b cm=%b want grant=0010 act=1 clast=%0d",
                 b, YouGotIt, tarActive, Clast, Clast_mstr, (b == MB));
      end
      adv();
    end
    settle();
    n_tests++;
    if ({YouGotIt, tarActive, Clast} !== '0) begin
      n_fail++;
      $display("FAIL single_turn: grant=%b act=%b clast=%b want all 0", YouGotIt, tarActive, Clast);
    end
    adv();
  endtask

  task automatic test_contention();
    int starts[$];
    int owners[$];
    int exp_own [5] = '{0, 1, 2, 3, 0};
    logic [NM-1:0] prev = '0;
    do_reset();
    need = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      settle();
      n_tests++;
      if (YouGotIt !== e_grant) begin
        n_fail++;
        $display("FAIL contention_grant c%0d: got %b want %b", c, YouGotIt, e_grant);
      end
      if (prev == '0 && YouGotIt != '0) begin
        starts.push_back(c);
        owners.push_back($clog2(YouGotIt));
      end
      prev = YouGotIt;
      adv();
    end
    n_tests++;
    if (owners.size() != 5) begin
      n_fail++;
      $display("FAIL contention_count: got %0d grants want 5", owners.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (owners[k] != exp_own[k] || starts[k] != 1 + 10 * k) begin
          n_fail++;
          $display("FAIL contention_order%0d: owner=%0d at c%0d want owner=%0d at c%0d",
                   k, owners[k], starts[k], exp_own[k], 1 + 10 * k);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    need = 4'b0100;
    adv();
    for (int b = 0; b < 3; b++) adv();
    need = 4'b0000;
    settle();
    n_tests++;
    if ({YouGotIt, tarActive, Clast, Clast_mstr} !== {4'b0100, 1'b0, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL early_release: grant=%b act=%b clast=%b want 0100/0/0", YouGotIt, tarActive, Clast);
    end
    adv();
    need = 4'b1111;
    settle();
    n_tests++;
    if (YouGotIt !== 4'b0000) begin
      n_fail++;
      $display("FAIL early_turn: got %b want 0000", YouGotIt);
    end
    adv();
    adv();
    settle();
    n_tests++;
`ifdef GBUS_FIXED_PRI_EN
    if (YouGotIt !== 4'b0001) begin
      n_fail++;
      $display("FAIL early_next_grant: got %b want 0001", YouGotIt);
    end
`else
    if (YouGotIt !== 4'b1000) begin
      n_fail++;
      $display("FAIL early_next_grant: got %b want 1000 (pointer 3)", YouGotIt);
    end
`endif
    adv();
  endtask

  task automatic test_datapath();
    do_reset();
    for (int i = 0; i < NM; i++) begin
      a_addr[i] = {16'($urandom()), $urandom()};
      a_dout[i] = 16'($urandom());
    end
    a_addr[1] = 48'h0000_1234_5678;
    a_dout[1] = 16'hBEEF;
    dataOut   = 16'hCAFE;
    need      = 4'b0010;
    settle();
    n_tests++;
    if ({Adr, dbus_in, DinMast} !== '0) begin
      n_fail++;
      $display("FAIL datapath_idle: adr=%h dbus=%h din=%h want 0", Adr, dbus_in, DinMast);
    end
    adv();
    settle();
    n_tests++;
    if ({Adr, dbus_in, DinMast} !== {48'h0000_1234_5678, 16'hBEEF, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL datapath_busy: adr=%h dbus=%h din=%h want 000012345678/beef/cafe", Adr, dbus_in, DinMast);
    end
    adv();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    need = 4'b0001;
    adv();
    for (int b = 0; b < 3; b++) adv();
    settle();
    n_tests++;
    if (tarActive !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_beat4: act=%b want 1", tarActive);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({YouGotIt, Clast_mstr, tarActive, Clast, Adr, dbus_in, DinMast} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: grant=%b act=%b adr=%h want all 0", YouGotIt, tarActive, Adr);
    end
    model_reset();
    need = 4'b1000;
    @(posedge clk);
    #2 rst_n = 1'b1;
    adv();
    settle();
    n_tests++;
    if (YouGotIt !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_regrant: got %b want 1000", YouGotIt);
    end
    adv();
  endtask

`ifdef GBUS_FIXED_PRI_EN
  task automatic test_fixed_pri();
    int seen0 = 0;
    do_reset();
    need = 4'b0101;
    for (int c = 0; c < 40; c++) begin
      settle();
      n_tests++;
      if (YouGotIt[2] !== 1'b0 || YouGotIt !== e_grant) begin
        n_fail++;
        $display("FAIL fixed_pri c%0d: got %b want %b", c, YouGotIt, e_grant);
      end
      if (YouGotIt[0]) seen0++;
      adv();
    end
    n_tests++;
    if (seen0 == 0) begin
      n_fail++;
      $display("FAIL fixed_pri_m0: master 0 granted %0d cycles want >0", seen0);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    need = 4'($urandom());
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NM; i++) begin
        a_addr[i] = {16'($urandom()), $urandom()};
        a_dout[i] = 16'($urandom());
        if ($urandom_range(0, 7) == 0) need[i] = ~need[i];
      end
      dataOut = 16'($urandom());
      settle();
      n_tests++;
      if (YouGotIt !== e_grant) begin
        n_fail++;
        $display("FAIL rand_grant c%0d: got %b want %b", c, YouGotIt, e_grant);
      end
      n_tests++;
      if ({tarActive, Clast, Clast_mstr} !== {e_act, e_clast, e_cmstr}) begin
        n_fail++;
        $display("FAIL rand_beat c%0d: act=%b clast=%b cm=%b want %b %b %b",
                 c, tarActive, Clast, Clast_mstr, e_act, e_clast, e_cmstr);
      end
      n_tests++;
      if ({Adr, dbus_in, DinMast} !== {e_adr, e_dbus, e_din}) begin
        n_fail++;
        $display("FAIL rand_data c%0d: adr=%h dbus=%h din=%h want %h %h %h",
                 c, Adr, dbus_in, DinMast, e_adr, e_dbus, e_din);
      end
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      a_addr[i] = '0;
      a_dout[i] = '0;
    end
    test_reset();
    test_single_burst();
    test_contention();
    test_early_release();
    test_datapath();
    test_reset_mid_burst();
`ifdef GBUS_FIXED_PRI_EN
    test_fixed_pri();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
